// File: rtl/vend_ctrl_if.sv
// Signal bundle between the vending controller and the coin acceptor, select
// buttons, dispenser and change hopper.
interface vend_ctrl_if;
    logic [1:0] coin;
    logic [1:0] sel;
    logic       cancel;
    // disp_req is a level request held until disp_ack is sampled high; the
    // dispense completes on the first edge where both are high, and disp_ack
    // is ignored whenever disp_req is low.
    logic       disp_ack;
    logic       disp_req;
    logic       disp_item;
    logic       change_dime;
    logic       change_nickel;
    logic       coin_reject;
    logic       short_credit;
    logic [5:0] credit;
    logic       busy;
    logic [1:0] dbg_state;

    modport master (
        output coin, sel, cancel, disp_ack,
        input  disp_req, disp_item, change_dime, change_nickel, coin_reject,
               short_credit, credit, busy, dbg_state
    );

    modport slave (
        input  coin, sel, cancel, disp_ack,
        output disp_req, disp_item, change_dime, change_nickel, coin_reject,
               short_credit, credit, busy, dbg_state
    );
endinterface

// File: rtl/vend_ctrl.sv
// Two-price vending controller: accumulates coin credit, runs the dispenser
// handshake and pays change back as dime/nickel pulses.
module vend_ctrl #(
    parameter int PRICE_A    = 15,
    parameter int PRICE_B    = 20,
    parameter int MAX_CREDIT = 35,
    parameter int TIMEOUT    = 16
) (
    input  logic        clock,
    input  logic        reset,
    vend_ctrl_if.slave  bus
);
    localparam int         TW    = $clog2(TIMEOUT);
    localparam logic [5:0] PA    = 6'(PRICE_A);
    localparam logic [5:0] PB    = 6'(PRICE_B);
    localparam logic [6:0] MAXC  = 7'(MAX_CREDIT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    credit_q, credit_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          item_q, item_d;
    logic          dime_q, dime_d;
    logic          nickel_q, nickel_d;
    logic          reject_q, reject_d;
    logic          short_q, short_d;

    logic [6:0] coin_val;
    logic [6:0] sum;
    logic       coin_in;
    logic       sel_valid;
    logic [5:0] price;

    always_comb begin
        case (bus.coin)
            2'b01:   coin_val = 7'd5;
            2'b10:   coin_val = 7'd10;
            2'b11:   coin_val = 7'd25;
            default: coin_val = 7'd0;
        endcase
        coin_in   = (bus.coin != 2'b00);
        sum       = {1'b0, credit_q} + coin_val;
        sel_valid = (bus.sel == 2'b01) || (bus.sel == 2'b10);
        price     = bus.sel[1] ? PB : PA;
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        item_d   = item_q;
        dime_d   = 1'b0;
        nickel_d = 1'b0;
        reject_d = 1'b0;
        short_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                credit_d = 6'd0;
                timer_d  = '0;
                if (coin_in) begin
                    if (coin_val <= MAXC) begin
                        credit_d = coin_val[5:0];
                        state_d  = S_CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_CREDIT: begin
                if (coin_in) begin
                    if (sum <= MAXC) credit_d = sum[5:0];
                    else             reject_d = 1'b1;
                end
                // credit_d now holds post-coin credit for refund and price checks
                if (bus.cancel) begin
                    state_d = S_CHANGE;
                    timer_d = '0;
                end else if (sel_valid) begin
                    timer_d = '0;
                    if (credit_d >= price) begin
                        credit_d = credit_d - price;
                        item_d   = bus.sel[1];
                        state_d  = S_DISPENSE;
                    end else begin
                        short_d = 1'b1;
                    end
                end else if (coin_in) begin
                    timer_d = '0;
                end else if (timer_q == TLAST) begin
                    state_d = S_CHANGE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DISPENSE: begin
                reject_d = coin_in;
                if (bus.disp_ack) state_d = (credit_q != 6'd0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                reject_d = coin_in;
                if (credit_q >= 6'd10) begin
                    dime_d   = 1'b1;
                    credit_d = credit_q - 6'd10;
                end else if (credit_q != 6'd0) begin
                    nickel_d = 1'b1;
                    credit_d = credit_q - 6'd5;
                end
                if (credit_d == 6'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            credit_q <= 6'd0;
            timer_q  <= '0;
            item_q   <= 1'b0;
            dime_q   <= 1'b0;
            nickel_q <= 1'b0;
            reject_q <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            item_q   <= item_d;
            dime_q   <= dime_d;
            nickel_q <= nickel_d;
            reject_q <= reject_d;
            short_q  <= short_d;
        end
    end

    assign bus.disp_req      = (state_q == S_DISPENSE);
    assign bus.busy          = (state_q == S_DISPENSE) || (state_q == S_CHANGE);
    assign bus.disp_item     = item_q;
    assign bus.change_dime   = dime_q;
    assign bus.change_nickel = nickel_q;
    assign bus.coin_reject   = reject_q;
    assign bus.short_credit  = short_q;
    assign bus.credit        = credit_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Multi-product vending controller for the newspaper/vending datapath.
- Accumulates coin credit and checks it against two parameterized prices.
- Sequences a dispenser over a req/ack handshake, then returns change as dime and nickel pulses.
- Sits between the coin acceptor / select buttons and the dispenser and change hopper; replaces the single-price fixed FSM.

Parameters:
- PRICE_A, 15, price of item A in cents (multiple of 5, at most MAX_CREDIT)
- PRICE_B, 20, price of item B in cents (multiple of 5, at most MAX_CREDIT)
- MAX_CREDIT, 35, highest credit accepted in cents (multiple of 5, at most 60)
- TIMEOUT, 16, idle cycles in CREDIT before auto-refund (at least 2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- coin  in  2  one-cycle coin pulse: 00 none, 01 nickel (5), 10 dime (10), 11 quarter (25)
- sel  in  2  one-cycle select: 01 item A, 10 item B; 00 and 11 ignored
- cancel  in  1  one-cycle refund request
- disp_ack  in  1  dispenser done; valid only while disp_req is high
- disp_req  out  1  dispense request, level, held until ack
- disp_item  out  1  0 = A, 1 = B; stable while disp_req is high
- change_dime  out  1  one-cycle pulse per 10c returned
- change_nickel  out  1  one-cycle pulse per 5c returned
- coin_reject  out  1  one-cycle pulse: coin not credited, acceptor must return it
- short_credit  out  1  one-cycle pulse: valid select with insufficient credit
- credit  out  6  current credit in cents, unsigned
- busy  out  1  high in DISPENSE and CHANGE

Behaviour:
- Reset: all outputs and the timer go to 0; state goes to IDLE.
- Reset mid-operation: disp_req drops immediately and credit is discarded.
- All outputs are registered; events sampled in cycle N appear in cycle N+1.
- States: IDLE, CREDIT, DISPENSE, CHANGE.
- IDLE: credit = 0. A nonzero coin adds its value and moves to CREDIT. sel and cancel are ignored.
- CREDIT, evaluated in this order within one cycle:
  - Coin: if credit+value <= MAX_CREDIT, add it; otherwise pulse coin_reject and leave credit unchanged.
  - cancel: go to CHANGE. Any coin accepted in the same cycle is included in the refund.
  - Valid sel: compare price against the post-coin credit.
    - If credit >= price: credit -= price, latch disp_item, go to DISPENSE. disp_req is high in cycle N+1.
    - Otherwise: pulse short_credit and stay in CREDIT.
- Timer in CREDIT:
  - Reloads to 0 on any accepted coin, rejected coin or sel.
  - Otherwise increments each cycle.
  - When it reaches TIMEOUT-1, go to CHANGE (auto-refund).
- DISPENSE:
  - disp_req is held high.
  - Sampling disp_ack = 1 moves to CHANGE if credit > 0, else IDLE. disp_req is low the next cycle.
  - disp_ack while disp_req is low is ignored.
  - No dispenser timeout.
- CHANGE: each cycle, if credit >= 10, pulse change_dime and subtract 10; otherwise pulse change_nickel and subtract 5.
  - The edge that takes credit to 0 moves to IDLE.
  - If CHANGE is entered with credit = 0, go to IDLE with no pulse.
- Coins arriving in DISPENSE or CHANGE: pulse coin_reject, no credit. sel and cancel are ignored.
- change_dime and change_nickel are never high together.
- Credit arithmetic is 6-bit unsigned and never exceeds MAX_CREDIT. Subtraction never underflows because price <= credit is checked first.

Test Plan:
- Three nickels, then sel=01:
  - credit steps 5, 10, 15.
  - disp_req=1, disp_item=0 one cycle after sel.
  - ack: back to IDLE, no change pulses.
- Quarter + dime (credit 35), then sel=10:
  - Dispense B.
  - After ack: exactly one change_dime and one change_nickel pulse on consecutive cycles (15c), then IDLE with credit 0.
- Overflow and ordering:
  - Quarter + dime (35), then a nickel: coin_reject pulse, credit stays 35.
  - Cancel: three pulses (dime, dime, dime... total 30) then nickel (5), credit 0, IDLE.
- Insufficient and timeout:
  - Dime, then sel=10: short_credit pulse, credit stays 10.
  - No activity for TIMEOUT cycles: one change_dime, then IDLE.
- Simultaneous coin and sel: credit 10 plus a nickel and sel=01 in the same cycle -> dispense A, credit 0, no change.
- Reset during DISPENSE with disp_req high:
  - Async reset drops disp_req and credit to 0 before the next edge.
  - After release, a nickel gives credit 5.
  - A stray disp_ack in IDLE has no effect.
